// File: rtl/gpc_arb_pkg.sv
// Shared definitions for the Gray-indexed round-robin arbiter.
//   - arb_state_t : FSM state encoding (ARB_IDLE=0, ARB_GRANT=1)
//   - bin2gray    : binary to Gray conversion. It works on 32 bits; callers
//                   truncate to their index width. This is exact because each
//                   Gray bit depends only on the same and next-higher binary
//                   bit, and the zero-extended upper bits contribute nothing.
//   - wrap_inc    : increment modulo n, using an explicit compare against n-1
package gpc_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // The compare against n-1 keeps the wrap correct when n is not a power of 2.
  function automatic int wrap_inc(input int value, input int n);
    return (value == n - 1) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/gray_rr_arbiter_rr_pick.sv
// Rotating first-set-bit search. This block is purely combinational.
// It searches req in the order ptr, ptr+1, ..., wrapping from NR_REQ-1 to 0.
//   req   : request vector
//   ptr   : highest-priority index; must be below NR_REQ
//   found : at least one request is set
//   pick  : index of the first set request in rotated order (0 when none)
module rr_pick #(
  parameter int NR_REQ    = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NR_REQ-1:0]    req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] pick
);

  localparam logic [IDX_WIDTH:0] NR_EXT = (IDX_WIDTH + 1)'(NR_REQ);

  logic [IDX_WIDTH:0]   cand_sum [NR_REQ];
  logic [IDX_WIDTH-1:0] cand_idx [NR_REQ];
  logic [NR_REQ-1:0]    cand_hit;

  // Candidate gi is the requester at rotated position gi, counted from ptr.
  // The extra sum bit means ptr+gi cannot overflow before the modulo step.
  generate
    for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, ptr} + (IDX_WIDTH + 1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= NR_EXT)
                          ? IDX_WIDTH'(cand_sum[gi] - NR_EXT)
                          : IDX_WIDTH'(cand_sum[gi]);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // The loop scans downward, so the lowest rotated position that is set wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        found = 1'b1;
        pick  = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/gray_rr_arbiter.sv
// Round-robin arbiter with a hold timeout. It shares one resource among
// NR_REQ requesters and publishes the owner index in both binary and Gray code.
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-high
//   req          : per-requester request level
//   done         : per-requester release pulse; only the current owner's bit counts
//   gnt          : one-hot grant, registered
//   gnt_valid    : high while any grant is asserted
//   gnt_idx_bin  : index of the current or last owner, binary
//   gnt_idx_gray : the same index in Gray code
//   timeout      : one-cycle pulse after an ownership is ended by the hold limit
module gray_rr_arbiter
  import gpc_arb_pkg::*;
#(
  parameter int NR_REQ     = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int MAX_HOLD   = 15,
  parameter int HOLD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR_REQ-1:0]    req,
  input  logic [NR_REQ-1:0]    done,
  output logic [NR_REQ-1:0]    gnt,
  output logic                 gnt_valid,
  output logic [IDX_WIDTH-1:0] gnt_idx_bin,
  output logic [IDX_WIDTH-1:0] gnt_idx_gray,
  output logic                 timeout
);

  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
    HOLD_WIDTH'(HOLD_EN ? MAX_HOLD - 1 : 0);

  arb_state_t             state_reg,   state_next;
  logic [NR_REQ-1:0]      gnt_reg,     gnt_next;
  logic [IDX_WIDTH-1:0]   idx_reg,     idx_next;
  logic [IDX_WIDTH-1:0]   ptr_reg,     ptr_next;
  logic [HOLD_WIDTH-1:0]  hold_reg,    hold_next;
  logic                   timeout_reg, timeout_next;

  logic                   found;
  logic [IDX_WIDTH-1:0]   pick;
  logic                   owner_done;
  logic                   owner_req;
  logic                   hold_limit;
  logic                   release_now;

  rr_pick #(
    .NR_REQ   (NR_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_reg),
    .found(found),
    .pick (pick)
  );

  // Masking with the one-hot grant picks out the owner's bits and ignores
  // everyone else. In IDLE the grant is zero, so both terms are zero.
  assign owner_done  = |(done & gnt_reg);
  assign owner_req   = |(req & gnt_reg);
  assign hold_limit  = HOLD_EN && (hold_reg == HOLD_LAST);
  assign release_now = owner_done || !owner_req || hold_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      gnt_reg     <= '0;
      idx_reg     <= '0;
      ptr_reg     <= '0;
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      idx_reg     <= idx_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    idx_next     = idx_reg;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (found) begin
          state_next = ARB_GRANT;
          gnt_next   = NR_REQ'(1) << pick;
          idx_next   = pick;
          hold_next  = '0;
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          // The owner drops to lowest priority; the index outputs keep its value.
          state_next   = ARB_IDLE;
          gnt_next     = '0;
          ptr_next     = IDX_WIDTH'(wrap_inc(int'(idx_reg), NR_REQ));
          hold_next    = '0;
          // A timeout is reported only when the hold limit was the sole cause.
          timeout_next = hold_limit && !owner_done && owner_req;
        end else begin
          hold_next = hold_reg + HOLD_WIDTH'(1);
        end
      end
      default: begin
        state_next = ARB_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign gnt          = gnt_reg;
  assign gnt_valid    = |gnt_reg;
  assign gnt_idx_bin  = idx_reg;
  // Gray is derived combinationally from the registered binary index,
  // so both index outputs change on the same clock edge.
  assign gnt_idx_gray = IDX_WIDTH'(bin2gray(32'(idx_reg)));
  assign timeout      = timeout_reg;

endmodule

// File: tb/tb_gray_rr_arbiter.sv
module tb_gray_rr_arbiter;

  localparam int NR = 4;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx_bin;
  logic [1:0] gnt_idx_gray;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Behavioural model: who owns the resource, for how many cycles,
  // and who gets first look next time.
  int m_owner  = -1;
  int m_last   = 0;
  int m_ptr    = 0;
  int m_cycles = 0;
  bit m_tmo    = 0;

  always #5 clk = ~clk;

  gray_rr_arbiter #(
    .NR_REQ    (NR),
    .IDX_WIDTH (2),
    .MAX_HOLD  (MH),
    .HOLD_WIDTH(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_idx_bin (gnt_idx_bin),
    .gnt_idx_gray(gnt_idx_gray),
    .timeout     (timeout)
  );

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] dn;
    logic [3:0] e_gnt;
    logic [1:0] e_bin;
    logic [1:0] e_gray;
    logic       e_tmo;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [3:0] rq, input logic [3:0] dn);
    bit by_done, by_drop, by_limit;
    m_tmo = 0;
    if (r) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_cycles = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (m_ptr + i) % NR;
        if (rq[c]) begin
          m_owner = c; m_last = c; m_cycles = 1;
          break;
        end
      end
    end else begin
      by_done  = dn[m_owner];
      by_drop  = !rq[m_owner];
      by_limit = (MH != 0) && (m_cycles == MH);
      if (by_done || by_drop || by_limit) begin
        m_tmo   = by_limit && !by_done && !by_drop;
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end else begin
        m_cycles++;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    int e_gnt;
    e_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
    check({tag, ".gnt"},   int'(gnt), e_gnt);
    check({tag, ".valid"}, int'(gnt_valid), int'(e_gnt != 0));
    check({tag, ".bin"},   int'(gnt_idx_bin), m_last);
    check({tag, ".gray"},  int'(gnt_idx_gray), m_last ^ (m_last >> 1));
    check({tag, ".tmo"},   int'(timeout), int'(m_tmo));
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] rq, input logic [3:0] dn);
    @(negedge clk);
    rst = r; req = rq; done = dn;
    @(posedge clk);
    model_update(r, rq, dn);
    #1;
    compare_model(tag);
    $display("%s rst=%0b req=%b done=%b -> gnt=%b idx=%0d gray=%0d tmo=%0b",
             tag, r, rq, dn, gnt, gnt_idx_bin, gnt_idx_gray, timeout);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] b,
                            input logic [1:0] gy, input logic t);
    check({tag, ".gnt"},   int'(gnt), int'(g));
    check({tag, ".valid"}, int'(gnt_valid), int'(|g));
    check({tag, ".bin"},   int'(gnt_idx_bin), int'(b));
    check({tag, ".gray"},  int'(gnt_idx_gray), int'(gy));
    check({tag, ".tmo"},   int'(timeout), int'(t));
  endtask

  initial begin
    logic [3:0] rq_r;
    logic [3:0] dn_r;
    logic       r_r;
    int         o;
    logic [1:0] gray_seq [5];
    gray_seq[0] = 2'd0; gray_seq[1] = 2'd1; gray_seq[2] = 2'd3;
    gray_seq[3] = 2'd2; gray_seq[4] = 2'd0;

    // Reset, first grant, drop release, then a hold-limit timeout and regrant.
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd3, 1'b0};
    vecs[5]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd3, 1'b0};
    vecs[6]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd3, 1'b0};
    vecs[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd3, 1'b0};
    vecs[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 2'd3, 1'b1};
    vecs[9]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd3, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 2'd3, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 2'd3, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].rq, vecs[i].dn);
      expect_out($sformatf("vec%0d.tbl", i), vecs[i].e_gnt, vecs[i].e_bin,
                 vecs[i].e_gray, vecs[i].e_tmo);
    end

    // All four requesting; each owner pulses done in its second grant cycle.
    step("rr.rst", 1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      step($sformatf("rr%0d.g1", k), 1'b0, 4'b1111, 4'b0000);
      expect_out($sformatf("rr%0d.g1x", k), 4'(1 << o), 2'(o), gray_seq[k], 1'b0);
      step($sformatf("rr%0d.g2", k), 1'b0, 4'b1111, 4'b0000);
      step($sformatf("rr%0d.rel", k), 1'b0, 4'b1111, 4'(1 << o));
      expect_out($sformatf("rr%0d.relx", k), 4'b0000, 2'(o), gray_seq[k], 1'b0);
    end

    // Owner 3 releases by done; the pointer wraps to 0.
    step("wrap.rst", 1'b1, 4'b0000, 4'b0000);
    step("wrap.g3", 1'b0, 4'b1000, 4'b0000);
    step("wrap.rel", 1'b0, 4'b1001, 4'b1000);
    step("wrap.g0", 1'b0, 4'b1001, 4'b0000);
    expect_out("wrap.g0x", 4'b0001, 2'd0, 2'd0, 1'b0);

    // done from a non-owner is ignored; dropping req releases without a timeout.
    step("nd.rst", 1'b1, 4'b0000, 4'b0000);
    step("nd.g1", 1'b0, 4'b0010, 4'b0000);
    step("nd.d2", 1'b0, 4'b0010, 4'b0100);
    expect_out("nd.d2x", 4'b0010, 2'd1, 2'd1, 1'b0);
    step("nd.drop", 1'b0, 4'b0000, 4'b0000);
    expect_out("nd.dropx", 4'b0000, 2'd1, 2'd1, 1'b0);

    // Reset in the middle of a grant clears everything, including the pointer.
    step("mr.rst", 1'b1, 4'b0000, 4'b0000);
    step("mr.g2", 1'b0, 4'b0100, 4'b0000);
    step("mr.hold", 1'b0, 4'b0100, 4'b0000);
    step("mr.rst2", 1'b1, 4'b0100, 4'b0000);
    expect_out("mr.rst2x", 4'b0000, 2'd0, 2'd0, 1'b0);
    step("mr.g1", 1'b0, 4'b0110, 4'b0000);
    expect_out("mr.g1x", 4'b0010, 2'd1, 2'd1, 1'b0);

    // Randomized traffic against the model.
    rq_r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq_r = 4'($urandom);
      dn_r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      r_r  = ($urandom_range(0, 99) == 0);
      step($sformatf("rnd%0d", i), r_r, rq_r, dn_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_rr_arbiter.md
Name: gray_rr_arbiter

Overview:
Round-robin arbiter that shares one resource among NR_REQ requesters.
- Grant is held until the owner signals done, drops its request, or exceeds a maximum hold time.
- The granted index is published in binary and in Gray code, so downstream Gray-keyed selects and status displays can use it directly.
- Sits between requesting units and the shared datapath select.

Parameters:
NR_REQ, 4, number of requesters (need not be a power of 2; minimum 2)
IDX_WIDTH, 2, width of the grant index; must satisfy 2**IDX_WIDTH >= NR_REQ
MAX_HOLD, 15, maximum consecutive grant cycles per ownership; 0 disables the timeout
HOLD_WIDTH, 4, hold counter width; must hold MAX_HOLD-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  NR_REQ  per-requester request level
done  input  NR_REQ  per-requester release pulse; honoured only for the current owner
gnt  output  NR_REQ  one-hot grant, registered
gnt_valid  output  1  high while any grant is asserted
gnt_idx_bin  output  IDX_WIDTH  index of current or last owner, binary
gnt_idx_gray  output  IDX_WIDTH  same index in Gray code, equal to bin ^ (bin >> 1)
timeout  output  1  one-cycle pulse when an ownership was force-released

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; gnt=0; gnt_valid=0; gnt_idx_bin=0; gnt_idx_gray=0; timeout=0; priority pointer ptr=0; hold_cnt=0.
  - Reset mid-grant drops the grant in the next cycle without a timeout pulse.
- State IDLE:
  - If req is nonzero, pick the first set bit searching ptr, ptr+1, ..., wrapping NR_REQ-1 to 0.
  - Next cycle: gnt=onehot(pick), gnt_valid=1, gnt_idx_bin=pick, gnt_idx_gray=gray(pick), hold_cnt=0, state=GRANT.
  - If req=0, remain in IDLE.
  - Latency: request sampled at edge t gives grant visible after edge t+1, i.e. 1 cycle.
- State GRANT (owner o):
  - Release condition at an edge: done[o] | ~req[o] | (MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1).
  - On release: state=IDLE, gnt=0, gnt_valid=0, ptr=(o+1) mod NR_REQ.
  - gnt_idx_bin and gnt_idx_gray keep value o.
  - timeout=1 for that single IDLE cycle only if the release was caused solely by the hold limit; otherwise timeout=0.
  - Without release: hold_cnt increments. A timed-out grant therefore lasts exactly MAX_HOLD cycles.
- Bubble: every release is followed by exactly one IDLE cycle with gnt=0, so the earliest next grant is 2 cycles after the release edge.
- Simultaneous events:
  - done[o] together with hold limit: counts as a normal release, timeout=0.
  - done[o] together with ~req[o]: one release.
  - done[j] for j!=o: ignored.
  - done in IDLE: ignored.
  - req bits of non-owners never affect the current grant.
- The timed-out owner becomes lowest priority via the ptr update and may be regranted only if no other requester is pending.
- Width rules:
  - ptr wrap uses an explicit compare against NR_REQ-1, not natural overflow.
  - Gray conversion is purely combinational on the registered binary index, so both indices change on the same edge.

Decomposition:
- Shared package/header gpc_arb_pkg holds:
  - state encoding constants (ARB_IDLE=0, ARB_GRANT=1);
  - a bin2gray function of width IDX_WIDTH;
  - a helper for wrap-increment modulo NR_REQ.
- One natural sub-module: rr_pick. It is combinational; inputs req and ptr, outputs found plus pick index. It implements the rotating first-set-bit search.
- The FSM, hold counter and output registers stay in gray_rr_arbiter.

Test Plan:
1. Reset, then NR_REQ=4, MAX_HOLD=4, req=0001 at cycle 0 -> cycle 1: gnt=0001, gnt_valid=1, idx_bin=0, idx_gray=0, timeout=0.
2. req=1111 held, done[owner] pulsed on each owner's 2nd grant cycle -> grant order 0,1,2,3,0; idx_gray sequence 0,1,3,2,0; exactly one gnt=0 cycle between owners.
3. req=0100 held, done never -> gnt=0100 for exactly 4 cycles, then one cycle gnt=0 with timeout=1, idx_bin=2, idx_gray=3; then regranted to 2.
4. Owner 3 releases via done with req=1001 -> ptr wraps to 0; next grant gnt=0001.
5. Owner 1 granted, done[2] pulsed and req[1] held -> grant unchanged. req[1] then dropped -> released next edge, timeout=0.
6. rst=1 during a grant to 2 -> next cycle gnt=0, all outputs 0, ptr=0. rst=0 with req=0010 -> grant to 1 one cycle later, idx_gray=1.
